// File: rtl/conv_pkg.sv
// Shared pixel type, signed helpers and pooling FSM states for the conv pipeline.
package conv_pkg;

   localparam int unsigned PIX_W = 16;

   typedef logic signed [PIX_W-1:0] pix_t;

   typedef enum logic {RUN, LAST} pool_state_t;

   function automatic pix_t pix_max(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic pix_t pix_relu(input pix_t a);
      return a[PIX_W-1] ? '0 : a;
   endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Half-width line buffer holding the horizontal pair maxima of the previous even row.
module maxpool_linebuf #(
   parameter int DEPTH = 49,
   parameter int W     = 16,
   parameter int AW    = 6
)(
   input  logic          clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/relu_maxpool2.sv
// Streaming ReLU + 2x2/stride-2 max-pool over a raster-ordered conv2 feature map.
module relu_maxpool2
   import conv_pkg::*;
#(
   parameter int SIZE      = 100,
   parameter int SIZEKer   = 3,
   parameter int WIDTH_BIT = PIX_W,
   parameter int RELU_EN   = 1
)(
   input  logic                        clock,
   input  logic                        nreset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH_BIT-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [WIDTH_BIT-1:0] out_data,
   output logic                        out_last,
   output logic                        done
);

   localparam int IN_SIZE = SIZE - SIZEKer + 1;
   localparam int POOL_W  = IN_SIZE / 2;
   localparam int CW      = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam int AW      = (POOL_W > 1) ? $clog2(POOL_W) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);
   localparam logic [CW-1:0] POOL_END = CW'(2 * POOL_W - 1);
   localparam bit ODD_IN = (IN_SIZE % 2) != 0;

   logic [CW-1:0] r_row, r_col;
   pix_t          r_pair, r_out_data;
   logic          r_out_valid, r_done;
   pool_state_t   r_state, w_next_state;

   logic          w_in_ready, w_accept, w_out_take, w_in_pool;
   logic          w_lb_we, w_produce, w_frame_end, w_done_set;
   pix_t          w_x, w_m, w_lb_rd;

   assign w_out_take = r_out_valid && out_ready;
   assign w_in_ready = !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;
   assign w_x        = (RELU_EN != 0) ? pix_relu(in_data) : in_data;
   assign w_m        = pix_max(r_pair, w_x);
   // With an odd map side the trailing row and column never complete a 2x2 window
   assign w_in_pool  = !ODD_IN || ((r_row != LAST_IDX) && (r_col != LAST_IDX));
   assign w_lb_we    = w_accept && w_in_pool && !r_row[0] && r_col[0];
   assign w_produce  = w_accept && w_in_pool && r_row[0] && r_col[0];
   assign w_frame_end = (r_row == POOL_END) && (r_col == POOL_END);

   maxpool_linebuf #(
      .DEPTH (POOL_W),
      .W     (WIDTH_BIT),
      .AW    (AW)
   ) u_linebuf (
      .clock   (clock),
      .i_we    (w_lb_we),
      .i_waddr (AW'(r_col >> 1)),
      .i_wdata (w_m),
      .i_raddr (AW'(r_col >> 1)),
      .o_rdata (w_lb_rd)
   );

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_row  <= '0;
         r_col  <= '0;
         r_pair <= '0;
      end else if (w_accept) begin
         if (!r_col[0]) r_pair <= w_x;
         if (r_col == LAST_IDX) begin
            r_col <= '0;
            r_row <= (r_row == LAST_IDX) ? '0 : r_row + CW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_produce) begin
         r_out_valid <= 1'b1;
         r_out_data  <= pix_max(w_lb_rd, w_m);
      end else if (w_out_take) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_state <= RUN;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_done_set;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RUN:     if (w_produce && w_frame_end) w_next_state = LAST;
         LAST:    if (w_out_take && !(w_produce && w_frame_end)) w_next_state = RUN;
         default: w_next_state = RUN;
      endcase
   end

   always_comb begin
      w_done_set = (r_state == LAST) && w_out_take;
      out_last   = (r_state == LAST) && r_out_valid;
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign done      = r_done;

endmodule
